fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
- Control end of the register-file FIFO.
- Accepts push/pop requests and owns the write and read pointers.
- Drives wr, rd, AddrWr and AddrRd of the RegFile; the RegFile holds the data and drives DataOut.
- Reports full, empty, almost_full, occupancy and one-cycle overflow/underflow error pulses.

Parameters:
- ws, package bus_definitions (4): word size. Not used internally; kept for consistency with RegFile.
- depth, package bus_definitions (8): number of words. Any value >= 2; need not be a power of 2.
- as, package bus_definitions ($clog2(depth)): address width.
- AF_LEVEL, depth-2: almost_full asserts when count >= AF_LEVEL. Legal range 1..depth.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- push  input  1  write request; data is presented to RegFile DataIn externally.
- pop  input  1  read request.
- wr  output  1  RegFile write enable.
- rd  output  1  RegFile read/output enable.
- AddrWr  output  as  RegFile write address = wr_ptr.
- AddrRd  output  as  RegFile read address = rd_ptr.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  as+1  current occupancy, 0..depth.
- overflow  output  1  registered pulse: the previous cycle rejected a push.
- underflow  output  1  registered pulse: the previous cycle rejected a pop.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Gating during reset: wr=0 and rd=0 in any cycle where reset=1, independent of push/pop.
- Accept rules (combinational):
  - pop_ok = pop & !empty & !reset
  - push_ok = push & !reset & (!full | pop_ok)
  - wr = push_ok, rd = pop_ok
- Read timing: RegFile output is combinational, so DataOut is valid in the same cycle rd=1 at AddrRd=rd_ptr. Zero-cycle read latency. When rd=0, DataOut floats (Z).
- Write timing: the word is stored at the clk edge ending the cycle in which wr=1 at AddrWr=wr_ptr. It is poppable from the next cycle onward.
- Pointers:
  - On push_ok: wr_ptr <= (wr_ptr==depth-1) ? 0 : wr_ptr+1.
  - On pop_ok: rd_ptr advances with the same wrap rule.
- Count update:
  - +1 on push_ok only, -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- flags (full, empty, almost_full) decode from count each cycle and are consistent with count in every cycle.
- Boundary: full, push & pop together. Both are accepted. The read returns the oldest word in that cycle, before the write edge overwrites the slot (wr_ptr==rd_ptr). Count stays at depth.
- Boundary: empty, push & pop together. No bypass: pop is rejected and underflow pulses next cycle. Push is accepted and count becomes 1.
- Boundary: full, push without pop. Push is rejected, overflow=1 next cycle, state unchanged.
- Boundary: empty, pop without push. Pop is rejected, underflow=1 next cycle.
- Error pulses: overflow and underflow are single-cycle, not sticky. They re-assert each cycle a rejection repeats.
- Reset mid-operation: the next edge with reset=1 returns all state to reset values. Stored RegFile data is ignored (the RegFile is not cleared by this block).
- State machine: implicit in count, with states EMPTY (0), PARTIAL (1..depth-1) and FULL (depth). Transitions follow the count rules above. An explicit enum is optional but must match count.

Decomposition:
- Package bus_definitions: ws, depth, as, and a typedef for count width as+1.
- Sub-module ptr_counter (as-bit wrap-at-depth-1 counter with inc and synchronous reset), instantiated twice for wr_ptr and rd_ptr.
- Count, flags and error logic stay in fifo_ctrl.
- Bench connects fifo_ctrl to RegFile for end-to-end checks.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, wr=0, rd=0, AddrWr=0, AddrRd=0.
- Push 8 words 0x1..0x8 (depth=8) -> count steps 1..8, almost_full=1 at count 6, full=1 after the 8th. A 9th push gives wr=0 and overflow=1 for one cycle.
- Pop 8 from full -> DataOut 0x1..0x8 in order, same cycle as rd. Empty=1 at end. A 9th pop gives rd=0, DataOut=Z, underflow=1.
- Wrap: push 5, pop 5, push 6 -> AddrWr wraps 7->0, pops return the 6 words in order, count correct throughout.
- Full with push+pop of 0xA -> rd=1 returning the oldest word, wr=1 at the same address, count stays 8, no overflow. Later pops return 0xA last.
- Empty with push+pop -> rd=0, wr=1, count=1, underflow pulse. Reset asserted with count=5 and push=1 -> wr=0, next cycle count=0, empty=1, pointers 0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the register-file FIFO: word size, depth, address/count widths
// and the occupancy state derived from count.
package bus_definitions;

    localparam int ws    = 4;
    localparam int depth = 8;
    localparam int as    = $clog2(depth);

    typedef logic [as-1:0] addr_t;
    typedef logic [as:0]   count_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fill_state_t;

    // Occupancy class of a given count; kept in lock-step with the count register.
    function automatic fill_state_t fill_state_of(count_t c);
        if (c == '0) begin
            return ST_EMPTY;
        end
        if (c == count_t'(depth)) begin
            return ST_FULL;
        end
        return ST_PARTIAL;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// Address pointer that steps by one on inc and wraps from depth-1 back to 0,
// so depth need not be a power of two.
module ptr_counter
    import bus_definitions::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [as-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == addr_t'(depth - 1)) ? '0 : value + addr_t'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Control end of the register-file FIFO: accepts push/pop, owns both pointers,
// drives the RegFile strobes/addresses and reports occupancy and error pulses.
module fifo_ctrl
    import bus_definitions::*;
#(
    parameter int AF_LEVEL = depth - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    output logic          wr,
    output logic          rd,
    output logic [as-1:0] AddrWr,
    output logic [as-1:0] AddrRd,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [as:0]   count,
    output logic          overflow,
    output logic          underflow
);

    fill_state_t state;
    count_t      count_next;
    logic        push_ok;
    logic        pop_ok;

    // A push into a full FIFO is still taken when a pop frees the slot in the same
    // cycle; the read sees the old word before the write edge replaces it.
    assign pop_ok  = pop & ~empty & ~reset;
    assign push_ok = push & ~reset & (~full | pop_ok);
    assign wr      = push_ok;
    assign rd      = pop_ok;

    ptr_counter u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .value (AddrWr)
    );

    ptr_counter u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .value (AddrRd)
    );

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + count_t'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - count_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            state     <= ST_EMPTY;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            state     <= fill_state_of(count_next);
            overflow  <= push & ~push_ok;
            underflow <= pop & ~pop_ok;
        end
    end

    assign empty       = (state == ST_EMPTY);
    assign full        = (state == ST_FULL);
    assign almost_full = (count >= count_t'(AF_LEVEL));

endmodule
